// File: rtl/piso_lr_pkg.sv
// Shared constants for the left/right serial link (transmitter and receiver).
// Holds state/direction encodings and the counter-width helper.
package piso_lr_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/lr_bit_counter.sv
// Enabled up-counter with synchronous clear and a terminal-count flag at WIDTH-1.
// Frames one word of the serial link; shared with the receiver.
module lr_bit_counter
    import piso_lr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/piso_lr_tx.sv
// Parallel-in serial-out transmitter, MSB-first or LSB-first per word,
// with a valid/ready handshake on the serial side and a done pulse per word.
module piso_lr_tx
    import piso_lr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             direction,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             busy,
    output logic             done
);

    localparam int CW = clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dir_q, dir_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_clr, cnt_en, cnt_tc;
    logic [CW-1:0]    cnt;

    lr_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        dir_d        = dir_q;
        sout_d       = sout_q;
        sout_valid_d = sout_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        case (state_q)
            S_IDLE: begin
                sout_d       = 1'b0;
                sout_valid_d = 1'b0;
                busy_d       = 1'b0;
                if (load) begin
                    state_d      = S_SHIFT;
                    shreg_d      = din;
                    dir_d        = direction;
                    cnt_clr      = 1'b1;
                    sout_d       = (direction == DIR_LEFT) ? din[WIDTH-1] : din[0];
                    sout_valid_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            S_SHIFT: begin
                if (sout_ready) begin
                    if (cnt_tc) begin
                        state_d      = S_IDLE;
                        sout_d       = 1'b0;
                        sout_valid_d = 1'b0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                        // sout already shows the outgoing end, so the next bit is one position in
                        if (dir_q == DIR_RIGHT) begin
                            shreg_d = shreg_q >> 1;
                            sout_d  = shreg_q[1];
                        end else begin
                            shreg_d = shreg_q << 1;
                            sout_d  = shreg_q[WIDTH-2];
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            dir_q        <= DIR_LEFT;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            dir_q        <= dir_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE) & ~reset;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/piso_lr_tx.md
Name: piso_lr_tx

Overview:
Parallel-in, serial-out transmitter with selectable shift direction. It is the sending end for the serial-in left/right shift register receiver. A WIDTH-bit word is loaded and emitted one bit per accepted cycle, MSB-first (left) or LSB-first (right), with a valid/ready handshake on the serial side. The block sits between a parallel producer and the serial link feeding the receiver.

Parameters:
WIDTH, 4, word width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
load  input  1  request to accept din/direction; honoured only when in_ready=1
din  input  WIDTH  parallel word to transmit
direction  input  1  0 = shift left (MSB first), 1 = shift right (LSB first); sampled with load
in_ready  output  1  high when a load will be accepted; equals (state==IDLE) & ~reset
sout  output  1  current serial bit
sout_valid  output  1  sout carries a valid bit
sout_ready  input  1  receiver accepts sout this cycle; a bit advances only when sout_valid & sout_ready
busy  output  1  high while the word is in flight (state SHIFT)
done  output  1  one-cycle pulse after the last bit is accepted

Behaviour:
- Reset (sync, active-high): state=IDLE, shreg=0, cnt=0, dir_q=0, sout=0, sout_valid=0, busy=0, done=0. Reset overrides everything, including mid-word; the partial word is discarded and no done is issued.
- All outputs are registered except in_ready, which is decoded from state.
- IDLE:
  - On an edge with load=1: shreg<=din, dir_q<=direction, cnt<=0, state<=SHIFT.
  - On the same edge: sout<=first bit (din[WIDTH-1] if direction=0, din[0] if direction=1), sout_valid<=1, busy<=1.
  - With load=0, outputs hold at idle values: sout=0, sout_valid=0, busy=0.
- SHIFT:
  - Edge with sout_ready=1 and cnt<WIDTH-1:
    - cnt<=cnt+1.
    - shreg shifts toward the outgoing end; the vacated bit fills with 0.
    - sout<=next bit. Bit k (k=0..WIDTH-1) is din[WIDTH-1-k] when dir_q=0, or din[k] when dir_q=1.
  - Edge with sout_ready=1 and cnt==WIDTH-1:
    - state<=IDLE, sout_valid<=0, sout<=0, busy<=0, done<=1.
  - Edge with sout_ready=0 (stall): sout, sout_valid, shreg and cnt all hold; there is no timeout.
- done is high for exactly one cycle, the cycle after the final accepted bit; it is cleared on the next edge.
- Latency: first bit is valid the cycle after load is accepted. With sout_ready held high, a word occupies WIDTH cycles of sout_valid, and done follows in the next cycle.
- Back-to-back: during the done cycle, state=IDLE and in_ready=1, so a load there is accepted. The minimum gap between words is one cycle with sout_valid=0.
- load while busy (in_ready=0) is ignored: no capture, no effect on the word in flight.
- A direction change during SHIFT has no effect; only dir_q is used.
- cnt width is clog2(WIDTH). The counter never wraps, because the transition to IDLE at WIDTH-1 is mandatory.

Decomposition:
- Shared package (piso_lr_pkg):
  - State encoding localparams: ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - Direction constants: DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
  - clog2 helper function.
- Sub-module lr_bit_counter: enabled up-counter with sync clear and terminal-count flag (cnt==WIDTH-1). It is reused by the receiver for word framing.
- Datapath (shreg, output bit select) and FSM remain in piso_lr_tx.

Test Plan:
- WIDTH=4, reset released, sout_ready=1, load 1 cycle with din=4'b1011, direction=0 -> sout_valid high 4 cycles with sout=1,0,1,1; done pulses in cycle 5; in_ready low during cycles 1-4.
- Same with direction=1 -> sout=1,1,0,1; done pulses 1 cycle after last bit; in_ready returns high at the done cycle.
- din=4'b0110, direction=0, sout_ready dropped for 3 cycles after bit 1 -> sout holds 1 with sout_valid=1 for the 3 stall cycles; sequence 0,1,1,0 completes; done appears exactly once.
- Load 4'b1100 (direction=0), then pulse load with din=4'b0011 and direction=1 during bit 2 -> second request ignored; output stays 1,1,0,0; busy unbroken.
- Reset asserted 1 cycle during bit 2 of 4'b1111 -> next cycle sout=0, sout_valid=0, busy=0, done=0, in_ready=1; a following load of 4'b1001 (direction=1) yields 1,0,0,1.
- Back-to-back: 4'b1010 (direction=0), then load asserted in the done cycle with 4'b0101 (direction=1) -> sout=1,0,1,0, one idle cycle, then 1,0,1,0; two done pulses.
